input_port_buffer: RTL and testbench

- Clocked ingress stage that sits directly upstream of a node's per-direction path computation input (in1..in4).
- Accepts 11-bit flits from a neighbouring link over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Computes the XY route code for each flit at enqueue and stores it alongside the flit.
- Presents the head flit and its route code to the path computation / merge stage over a second valid/ready handshake.

---
 rtl/input_port_buffer.sv | 110 +++++++++++
 tb/tb_input_port_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_buffer.sv
// Ingress buffer for one link direction. Flits arrive over a valid/ready
// handshake. Each flit's XY route code is computed when it is enqueued and
// stored next to it in a DEPTH-entry FIFO. The head flit and its route code
// go to the path computation stage over a second valid/ready handshake.
module input_port_buffer #(
    parameter int         DEPTH = 4,
    parameter logic [1:0] MY_X  = 2'd0,
    parameter logic [1:0] MY_Y  = 2'd0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [10:0]                    in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [10:0]                    out_data,
    output logic [2:0]                     out_route,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [7:0]                     flit_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Each entry is {route[2:0], flit[10:0]}.
    logic [13:0]      mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       flit_cnt_q, flit_cnt_d;

    logic             not_full;
    logic             push;
    logic             pop;
    logic [13:0]      head;

    // XY dimension-order routing: resolve X first, then Y, else deliver locally.
    function automatic logic [2:0] compute_route(input logic [10:0] flit);
        logic [1:0] dx;
        logic [1:0] dy;
        dx = flit[10:9];
        dy = flit[8:7];
        if (dx > MY_X)      return 3'b000;
        else if (dx < MY_X) return 3'b001;
        else if (dy > MY_Y) return 3'b010;
        else if (dy < MY_Y) return 3'b011;
        else                return 3'b100;
    endfunction

    // Handshake qualification. Acceptance depends only on the stored count,
    // so a full buffer never passes a flit through, even when a pop happens
    // in the same cycle.
    assign not_full  = (count_q != CNT_W'(DEPTH));
    assign push      = in_valid && not_full;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    assign in_ready  = not_full && !reset;
    assign out_valid = (count_q != '0);
    assign out_data  = reset ? 11'd0 : head[10:0];
    assign out_route = reset ? 3'd0 : head[13:11];
    assign count     = count_q;
    assign flit_cnt  = flit_cnt_q;

    // Next-state logic for pointers, occupancy and the dequeue counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        flit_cnt_d = flit_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            flit_cnt_d = flit_cnt_q + 8'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: async reset discards everything buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flit_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    // Storage: write flit plus its route code. Stale contents are harmless
    // because the pointers and count are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {compute_route(in_data), in_data};
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Randomized bench for input_port_buffer (DEPTH=4, node at 1,1). A queue
// holds the flits expected inside the buffer, and each flit's route is
// derived directly from the XY routing rules.
module tb_input_port_buffer;

    localparam int DEPTH = 4;
    localparam int MY_X  = 1;
    localparam int MY_Y  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [10:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [10:0] out_data;
    logic [2:0]  out_route;
    logic [2:0]  count;
    logic [7:0]  flit_cnt;

    logic [13:0] mq[$];
    int          m_flits = 0;
    int          nvec = 0;
    int          nerr = 0;

    input_port_buffer #(.DEPTH(DEPTH), .MY_X(2'd1), .MY_Y(2'd1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_route(out_route), .count(count),
        .flit_cnt(flit_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_route(input logic [10:0] f);
        int dx;
        int dy;
        dx = int'(f[10:9]);
        dy = int'(f[8:7]);
        if (dx > MY_X) return 3'd0;
        if (dx < MY_X) return 3'd1;
        if (dy > MY_Y) return 3'd2;
        if (dy < MY_Y) return 3'd3;
        return 3'd4;
    endfunction

    // Advance one clock edge and update the model from the inputs applied.
    task automatic tick();
        bit do_push;
        bit do_pop;
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = in_valid && (mq.size() != DEPTH) && !reset;
        @(posedge clk);
        if (do_pop) begin
            void'(mq.pop_front());
            m_flits = (m_flits + 1) % 256;
        end
        if (do_push) mq.push_back({ref_route(in_data), in_data});
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_flits = 0;
    endtask

    task automatic push_rand(input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = 11'($urandom);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 11'd0 || out_route !== 3'd0) begin
            nerr++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b out_data=%h out_route=%b want 0 0 000 0",
                     in_ready, out_valid, out_data, out_route);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_flits = 0;
        #1;
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || flit_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b count=%0d flit_cnt=%0d want 1 0 0 0",
                     in_ready, out_valid, count, flit_cnt);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_data = 11'b11_01_0000101;
        tick();
        in_valid = 1'b0;
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 11'h685 || out_route !== 3'b000 || count !== 3'd1) begin
            nerr++;
            $display("FAIL single_push: valid=%b data=%h route=%b count=%0d want 1 685 000 1",
                     out_valid, out_data, out_route, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        nvec++;
        if (count !== 3'd0 || flit_cnt !== 8'd1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL single_pop: count=%0d flit_cnt=%0d valid=%b want 0 1 0", count, flit_cnt, out_valid);
        end
    endtask

    task automatic test_fill_drain();
        logic [3:0] dl[4];
        logic [2:0] er[4];
        dl = '{4'b0001, 4'b0111, 4'b0100, 4'b0101};
        er = '{3'd1, 3'd2, 3'd3, 3'd4};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = {dl[i], 7'($urandom)};
            tick();
        end
        nvec++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL fill_full: count=%0d in_ready=%b want 4 0", count, in_ready);
        end
        in_data = 11'h7FF;
        tick();
        in_valid = 1'b0;
        nvec++;
        if (count !== 3'd4) begin
            nerr++;
            $display("FAIL fill_fifth_held: count=%0d want 4", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (out_valid !== 1'b1 || out_route !== er[i] || out_data !== mq[0][10:0]) begin
                nerr++;
                $display("FAIL drain_%0d: valid=%b route=%b data=%h want 1 %b %h",
                         i, out_valid, out_route, out_data, er[i], mq[0][10:0]);
            end
            tick();
        end
        out_ready = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            nerr++;
            $display("FAIL drain_empty: valid=%b count=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_full_pop_push();
        push_rand(4);
        in_valid = 1'b1;
        in_data = 11'($urandom);
        out_ready = 1'b1;
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL fullpop_ready_before: in_ready=%b want 0", in_ready);
        end
        tick();
        nvec++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL fullpop_only_pop: count=%0d in_ready=%b want 3 1", count, in_ready);
        end
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        nvec++;
        if (count !== 3'd4) begin
            nerr++;
            $display("FAIL fullpop_push_next: count=%0d want 4", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (out_data !== mq[0][10:0] || out_route !== mq[0][13:11]) begin
                nerr++;
                $display("FAIL fullpop_order_%0d: data=%h route=%b want %h %b",
                         i, out_data, out_route, mq[0][10:0], mq[0][13:11]);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        push_rand(2);
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_data = 11'($urandom);
            nvec++;
            if (count !== 3'd2 || out_data !== mq[0][10:0] || out_route !== mq[0][13:11]) begin
                nerr++;
                if (bad < 5)
                    $display("FAIL stream_%0d: count=%0d data=%h route=%b want 2 %h %b",
                             i, count, out_data, out_route, mq[0][10:0], mq[0][13:11]);
                bad++;
            end
            tick();
        end
        in_valid = 1'b0;
        nvec++;
        if (flit_cnt !== 8'd44 || count !== 3'd2) begin
            nerr++;
            $display("FAIL stream_wrap: flit_cnt=%0d count=%0d want 44 2", flit_cnt, count);
        end
        tick();
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [10:0] f;
        push_rand(3);
        nvec++;
        if (count !== 3'd3) begin
            nerr++;
            $display("FAIL areset_pre: count=%0d want 3", count);
        end
        #3;
        reset = 1'b1;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd0 || flit_cnt !== 8'd0 ||
            out_data !== 11'd0 || out_route !== 3'd0) begin
            nerr++;
            $display("FAIL areset_immediate: valid=%b in_ready=%b count=%0d flit_cnt=%0d data=%h route=%b want 0 0 0 0 000 0",
                     out_valid, in_ready, count, flit_cnt, out_data, out_route);
        end
        mq.delete();
        m_flits = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL areset_release: in_ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
        f = 11'($urandom);
        in_valid = 1'b1;
        in_data = f;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        nvec++;
        if (out_data !== f || out_route !== ref_route(f) || count !== 3'd1) begin
            nerr++;
            $display("FAIL areset_first: data=%h route=%b count=%0d want %h %b 1",
                     out_data, out_route, count, f, ref_route(f));
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data = 11'($urandom);
            nvec++;
            if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
                in_ready !== (mq.size() != DEPTH) || flit_cnt !== 8'(m_flits) ||
                (mq.size() != 0 && (out_data !== mq[0][10:0] || out_route !== mq[0][13:11]))) begin
                nerr++;
                if (bad < 5)
                    $display("FAIL random_%0d: count=%0d valid=%b in_ready=%b flit_cnt=%0d data=%h route=%b want count=%0d flit_cnt=%0d head=%h",
                             i, count, out_valid, in_ready, flit_cnt, out_data, out_route,
                             mq.size(), m_flits, (mq.size() != 0) ? mq[0] : 14'd0);
                bad++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_full_pop_push();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
